// File: rtl/ps_module_core.sv
// Power estimator: squares each accepted signed sample, sums squares into
// fixed-length blocks, and keeps a running total over the last H blocks.
// dout is the sum of squares over the most recent B*H accepted samples.
module ps_module_core #(
    parameter int DATA_WIDTH   = 16,
    parameter int UNIT_WIDTH   = 32,
    parameter int MID_WIDTH    = 37,
    parameter int OUTPUT_WIDTH = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [DATA_WIDTH-1:0]   din,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           data_valid
);

    localparam int CNT_W  = MID_WIDTH - UNIT_WIDTH;
    localparam int B      = 2 ** CNT_W;
    localparam int H_LOG  = OUTPUT_WIDTH - MID_WIDTH;
    localparam int H      = 2 ** H_LOG;
    localparam int BLK_W  = H_LOG + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(B - 1);
    localparam logic [BLK_W-1:0] BLK_FULL  = BLK_W'(H);

    // Stage 1: square register
    logic signed [PROD_W-1:0]     prod_s;
    logic [UNIT_WIDTH-1:0]        sq_q, sq_d;
    logic                         s1_vld_q, s1_vld_d;

    // Stage 2: block accumulator
    logic [MID_WIDTH-1:0]         acc_q, acc_d;
    logic [MID_WIDTH-1:0]         acc_sum_s;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [MID_WIDTH-1:0]         blk_sum_q, blk_sum_d;
    logic                         s2_vld_q, s2_vld_d;

    // Stage 3: block history and running total
    logic [MID_WIDTH-1:0]         hist_q [H];
    logic [MID_WIDTH-1:0]         hist_d [H];
    logic [MID_WIDTH-1:0]         oldest_s;
    logic [BLK_W-1:0]             blk_cnt_q, blk_cnt_d;
    logic [OUTPUT_WIDTH-1:0]      total_q, total_d;
    logic signed [OUTPUT_WIDTH-1:0] dout_q, dout_d;
    logic                         dv_q, dv_d;

    // Single multiplier; the square of a signed value is never negative
    assign prod_s = din * din;

    // Stage 1: capture the square of an accepted sample
    always_comb begin
        sq_d     = sq_q;
        s1_vld_d = 1'b0;
        if (en) begin
            sq_d     = UNIT_WIDTH'($unsigned(prod_s));
            s1_vld_d = 1'b1;
        end else begin
            sq_d     = sq_q;
            s1_vld_d = 1'b0;
        end
    end

    // Stage 2: accumulate squares; hand off and restart on the last sample of a block
    always_comb begin
        acc_sum_s = acc_q + MID_WIDTH'(sq_q);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        blk_sum_d = blk_sum_q;
        s2_vld_d  = 1'b0;
        if (s1_vld_q) begin
            if (cnt_q == CNT_LAST) begin
                blk_sum_d = acc_sum_s;
                acc_d     = {MID_WIDTH{1'b0}};
                cnt_d     = {CNT_W{1'b0}};
                s2_vld_d  = 1'b1;
            end else begin
                acc_d     = acc_sum_s;
                cnt_d     = cnt_q + CNT_W'(1);
                s2_vld_d  = 1'b0;
            end
        end else begin
            acc_d    = acc_q;
            s2_vld_d = 1'b0;
        end
    end

    // Stage 3: push block into history, update running total and output register
    always_comb begin
        if (blk_cnt_q == BLK_FULL) begin
            oldest_s = hist_q[H-1];
        end else begin
            oldest_s = {MID_WIDTH{1'b0}};
        end
        for (int i = 0; i < H; i++) begin
            hist_d[i] = hist_q[i];
        end
        blk_cnt_d = blk_cnt_q;
        total_d   = total_q;
        dout_d    = dout_q;
        dv_d      = 1'b0;
        if (s2_vld_q) begin
            hist_d[0] = blk_sum_q;
            for (int i = 1; i < H; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (blk_cnt_q == BLK_FULL) begin
                blk_cnt_d = blk_cnt_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
            total_d = total_q + OUTPUT_WIDTH'(blk_sum_q) - OUTPUT_WIDTH'(oldest_s);
            dout_d  = $signed(total_d);
            dv_d    = (blk_cnt_d == BLK_FULL);
        end else begin
            dv_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset taking priority over all traffic
    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_q      <= {UNIT_WIDTH{1'b0}};
            s1_vld_q  <= 1'b0;
            acc_q     <= {MID_WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            blk_sum_q <= {MID_WIDTH{1'b0}};
            s2_vld_q  <= 1'b0;
            for (int i = 0; i < H; i++) begin
                hist_q[i] <= {MID_WIDTH{1'b0}};
            end
            blk_cnt_q <= {BLK_W{1'b0}};
            total_q   <= {OUTPUT_WIDTH{1'b0}};
            dout_q    <= {OUTPUT_WIDTH{1'b0}};
            dv_q      <= 1'b0;
        end else begin
            sq_q      <= sq_d;
            s1_vld_q  <= s1_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            blk_sum_q <= blk_sum_d;
            s2_vld_q  <= s2_vld_d;
            for (int i = 0; i < H; i++) begin
                hist_q[i] <= hist_d[i];
            end
            blk_cnt_q <= blk_cnt_d;
            total_q   <= total_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
        end
    end

    assign dout       = dout_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_ps_module_core.sv
// Bench for ps_module_core: a sliding-window sum-of-squares model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_ps_module_core;

    localparam int DW  = 16;
    localparam int OW  = 40;
    localparam int BLK = 32;
    localparam int WIN = 256;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] din;
    logic signed [OW-1:0] dout;
    logic                 data_valid;

    always #5 clk = ~clk;

    ps_module_core #(
        .DATA_WIDTH  (16),
        .UNIT_WIDTH  (32),
        .MID_WIDTH   (37),
        .OUTPUT_WIDTH(40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .dout      (dout),
        .data_valid(data_valid)
    );

    int     tests  = 0;
    int     fails  = 0;
    bit     chk_on = 1'b0;

    // Model: window of the last WIN squares, plus a two-edge delay for results
    longint win[$];
    int     n_acc   = 0;
    longint m_dout  = 0;
    bit     m_valid = 1'b0;
    bit     p1 = 1'b0, p2 = 1'b0;
    longint p1_val = 0, p2_val = 0;
    bit     p1_full = 1'b0, p2_full = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic signed [DW-1:0] d);
        longint s;
        longint t;
        if (!r) begin
            win.delete();
            n_acc   = 0;
            m_dout  = 0;
            m_valid = 1'b0;
            p1 = 1'b0; p2 = 1'b0;
            p1_full = 1'b0; p2_full = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (p2) begin
                m_dout  = p2_val;
                m_valid = p2_full;
            end
            p2 = p1; p2_val = p1_val; p2_full = p1_full;
            p1 = 1'b0;
            if (e) begin
                s = longint'(d) * longint'(d);
                win.push_back(s);
                if (win.size() > WIN) void'(win.pop_front());
                n_acc++;
                if (n_acc % BLK == 0) begin
                    t = 0;
                    foreach (win[i]) t += win[i];
                    p1      = 1'b1;
                    p1_val  = t;
                    p1_full = (n_acc >= WIN);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return just after it
    task automatic step(input logic r, input logic e, input logic signed [DW-1:0] d);
        rst = r; en = e; din = d;
        @(posedge clk);
        model_edge(r, e, d);
        chk_on = 1'b1;
        #2;
    endtask

    task automatic repeat_step(input int n, input logic e, input logic signed [DW-1:0] d);
        for (int i = 0; i < n; i++) step(1'b1, e, d);
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("dout_cycle", dout, m_dout);
            check("valid_cycle", {63'd0, data_valid}, {63'd0, m_valid});
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; din = '0;

        // Reset held with active traffic
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'sd1000);
            check("rst_dout", dout, 64'sd0);
            check("rst_valid", {63'd0, data_valid}, 64'sd0);
        end

        // Constant 1: first pulse two edges after the 256th sample
        repeat_step(256, 1'b1, 16'sd1);
        step(1'b1, 1'b0, 16'sd0);
        check("ones_early_valid", {63'd0, data_valid}, 64'sd0);
        step(1'b1, 1'b0, 16'sd0);
        check("ones_first_valid", {63'd0, data_valid}, 64'sd1);
        check("ones_first_dout", dout, 64'sd256);
        step(1'b1, 1'b0, 16'sd0);
        check("ones_hold_valid", {63'd0, data_valid}, 64'sd0);
        check("ones_hold_dout", dout, 64'sd256);
        repeat_step(32, 1'b1, 16'sd1);
        repeat_step(2, 1'b0, 16'sd0);
        check("ones_second_valid", {63'd0, data_valid}, 64'sd1);
        check("ones_second_dout", dout, 64'sd256);

        // One block of 3s replaces the oldest block of 1s
        repeat_step(32, 1'b1, 16'sd3);
        repeat_step(2, 1'b0, 16'sd0);
        check("threes_valid", {63'd0, data_valid}, 64'sd1);
        check("threes_dout", dout, 64'sd512);

        // Most negative sample: full-scale output without overflow
        step(1'b0, 1'b0, 16'sd0);
        repeat_step(256, 1'b1, -16'sd32768);
        repeat_step(2, 1'b0, 16'sd0);
        check("maxneg_valid", {63'd0, data_valid}, 64'sd1);
        check("maxneg_dout", dout, 64'sd274877906944);

        // Alternating enable: ignored samples of 100 must not count
        step(1'b0, 1'b0, 16'sd0);
        for (int i = 0; i < 512; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, 16'sd2);
            else            step(1'b1, 1'b0, 16'sd100);
        end
        step(1'b1, 1'b0, 16'sd0);
        check("alt_valid", {63'd0, data_valid}, 64'sd1);
        check("alt_dout", dout, 64'sd1024);

        // Reset mid-block discards everything accumulated before it
        step(1'b0, 1'b0, 16'sd0);
        repeat_step(100, 1'b1, 16'sd5);
        step(1'b0, 1'b1, 16'sd5);
        repeat_step(255, 1'b1, 16'sd1);
        repeat_step(2, 1'b0, 16'sd0);
        check("post_rst_valid", {63'd0, data_valid}, 64'sd0);
        check("post_rst_partial_dout", dout, 64'sd224);
        step(1'b1, 1'b1, 16'sd1);
        repeat_step(2, 1'b0, 16'sd0);
        check("post_rst_first_valid", {63'd0, data_valid}, 64'sd1);
        check("post_rst_first_dout", dout, 64'sd256);

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
